apb_regfile_slave: RTL

APB completer that answers transfers issued by the team's APB master on the 8-bit-data / 9-bit-address peripheral bus. It holds a small bank of 8-bit registers. Register 0 is a read-only ID; the rest are read/write. It inserts a configurable number of wait states and flags illegal accesses on `pslverr`. One instance sits behind each `psel` line of the master.

---
 rtl/apb_regfile_slave.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/apb_regfile_slave.sv
// APB completer holding a small bank of 8-bit registers (reg 0 = read-only ID).
// Optional wait-state insertion is built only when APB_SLV_WAIT_EN is defined.
module apb_regfile_slave #(
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [7:0]  ID_VAL      = 8'hA5
) (
  input  logic       pclk,
  input  logic       presetn,
  input  logic       psel,
  input  logic       penable,
  input  logic       pwrite,
  input  logic [8:0] paddr,
  input  logic [7:0] pwdata,
  output logic [7:0] prdata,
  output logic       pready,
  output logic       pslverr,
  output logic [7:0] ctrl_out
);

  localparam int unsigned IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int unsigned DATA_W = 8;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_ERR    = 2'd2;

  logic [1:0]        state_q;
  logic [1:0]        state_d;

  logic              lat_write;
  logic              lat_err;
  logic [IDX_W-1:0]  lat_idx;
  logic [DATA_W-1:0] lat_wdata;

  logic [DATA_W-1:0] reg_q [NUM_REGS];

  logic              setup_c;
  logic              cnt_zero_c;
  logic              complete_c;
  logic              wr_en_c;
  logic [DATA_W-1:0] rd_data_c;

  assign setup_c = (state_q == S_IDLE) && psel && !penable;

  // Wait-state counter; absent build completes in the first access cycle.
`ifdef APB_SLV_WAIT_EN
  logic [3:0] cnt_q;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      cnt_q <= 4'd0;
    end else if (setup_c) begin
      cnt_q <= 4'(WAIT_CYCLES);
    end else if ((state_q == S_ACCESS) && (cnt_q != 4'd0)) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  assign cnt_zero_c = (cnt_q == 4'd0);
`else
  logic wait_unused;

  assign wait_unused = ^4'(WAIT_CYCLES);
  assign cnt_zero_c  = 1'b1;
`endif

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Setup-phase capture; the error decision is made here on all 9 address bits.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      lat_write <= 1'b0;
      lat_err   <= 1'b0;
      lat_idx   <= '0;
      lat_wdata <= '0;
    end else if (setup_c) begin
      lat_write <= pwrite;
      lat_err   <= (paddr >= 9'(NUM_REGS)) || (pwrite && (paddr == 9'd0));
      lat_idx   <= paddr[IDX_W-1:0];
      lat_wdata <= pwdata;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        reg_q[i] <= '0;
      end
    end else if (wr_en_c) begin
      reg_q[lat_idx] <= lat_wdata;
    end
  end

  assign rd_data_c = (lat_idx == '0) ? ID_VAL : reg_q[lat_idx];
  assign wr_en_c   = complete_c && lat_write && !lat_err;
  assign ctrl_out  = reg_q[1];

  // Next state and bus response, decoded from state and latched fields.
  always_comb begin
    state_d    = state_q;
    pready     = 1'b0;
    pslverr    = 1'b0;
    prdata     = '0;
    complete_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (psel) begin
          state_d = penable ? S_ERR : S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (!psel) begin
          state_d = S_IDLE;
        end else if (cnt_zero_c) begin
          pready  = 1'b1;
          pslverr = lat_err;
          prdata  = (lat_write || lat_err) ? '0 : rd_data_c;
          if (penable) begin
            complete_c = 1'b1;
            state_d    = S_IDLE;
          end
        end
      end
      S_ERR: begin
        pready  = 1'b1;
        pslverr = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
